// File: rtl/xpb_table_gen.sv
// xpb_table_gen: builds the XPB lookup table entry[i] = (i * base) mod modulus
// for i = 0..2**SEL_BITS-1. The table is built with one modular add per cycle
// and then served to the reducer through a registered 1-cycle lookup port.
//
// Handshake: start is a single-cycle pulse sampled while the FSM is idle.
// Starts that arrive during generation are ignored. A start with
// base >= modulus or modulus == 0 is rejected: err is set and the table is
// marked invalid. done pulses for one cycle when the table becomes valid, and
// ready stays high from then on. A lookup request (lookup_valid) sampled with
// ready high produces lookup_data and lookup_data_valid one cycle later.
// Otherwise lookup_data_valid is low and lookup_data holds its previous value.
module xpb_table_gen #(
  parameter int WIDTH    = 1024,
  parameter int SEL_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    base,
  input  logic [WIDTH-1:0]    modulus,
  output logic                busy,
  output logic                done,
  output logic                ready,
  output logic                err,
  input  logic                lookup_valid,
  input  logic [SEL_BITS-1:0] lookup_sel,
  output logic [WIDTH-1:0]    lookup_data,
  output logic                lookup_data_valid
);

  localparam int N = 1 << SEL_BITS;
  localparam logic [SEL_BITS-1:0] IDX_ONE  = {{(SEL_BITS-1){1'b0}}, 1'b1};
  localparam logic [SEL_BITS-1:0] IDX_LAST = {SEL_BITS{1'b1}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [SEL_BITS-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]      base_q, base_d;
  logic [WIDTH-1:0]      mod_q, mod_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [WIDTH-1:0]      lookup_data_q, lookup_data_d;
  logic                  lookup_data_valid_q, lookup_data_valid_d;

  // Table storage carries no reset; ready_q alone says whether it is valid.
  logic [WIDTH-1:0]      entry_q [N];
  logic                  wr_en;
  logic [SEL_BITS-1:0]   wr_idx;
  logic [WIDTH-1:0]      wr_data;

  logic                  operands_ok;
  logic [WIDTH:0]        sum;
  logic [WIDTH-1:0]      diff;
  logic [WIDTH-1:0]      red;

  // Next entry is acc + base reduced by one conditional subtract. Because
  // acc < M and base < M, the sum is below 2M. So when sum >= M, the true
  // difference fits in WIDTH bits and the wrapped subtraction gives it exactly.
  always_comb begin
    operands_ok = (modulus != '0) && (base < modulus);
    sum         = {1'b0, acc_q} + {1'b0, base_q};
    diff        = sum[WIDTH-1:0] - mod_q;
    red         = (sum >= {1'b0, mod_q}) ? diff : sum[WIDTH-1:0];
  end

  // FSM next state, generation datapath and table write control.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    base_d  = base_q;
    mod_d   = mod_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    wr_data = red;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (operands_ok) begin
            base_d  = base;
            mod_d   = modulus;
            acc_d   = '0;
            idx_d   = IDX_ONE;
            ready_d = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            wr_en   = 1'b1;
            wr_idx  = '0;
            wr_data = '0;
            state_d = ST_GEN;
          end else begin
            err_d   = 1'b1;
            ready_d = 1'b0;
          end
        end
      end
      ST_GEN: begin
        wr_en   = 1'b1;
        wr_idx  = idx_q;
        wr_data = red;
        acc_d   = red;
        idx_d   = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lookup port: serve only while the table is valid, otherwise hold the data.
  always_comb begin
    lookup_data_d       = lookup_data_q;
    lookup_data_valid_d = 1'b0;
    if (lookup_valid && ready_q) begin
      lookup_data_d       = entry_q[lookup_sel];
      lookup_data_valid_d = 1'b1;
    end
  end

  // Control and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= ST_IDLE;
      acc_q               <= '0;
      idx_q               <= '0;
      base_q              <= '0;
      mod_q               <= '0;
      busy_q              <= 1'b0;
      done_q              <= 1'b0;
      ready_q             <= 1'b0;
      err_q               <= 1'b0;
      lookup_data_q       <= '0;
      lookup_data_valid_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      acc_q               <= acc_d;
      idx_q               <= idx_d;
      base_q              <= base_d;
      mod_q               <= mod_d;
      busy_q              <= busy_d;
      done_q              <= done_d;
      ready_q             <= ready_d;
      err_q               <= err_d;
      lookup_data_q       <= lookup_data_d;
      lookup_data_valid_q <= lookup_data_valid_d;
    end
  end

  // Table write port, one entry per cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_q[wr_idx] <= wr_data;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign ready             = ready_q;
  assign err               = err_q;
  assign lookup_data       = lookup_data_q;
  assign lookup_data_valid = lookup_data_valid_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Bench for xpb_table_gen: a small instance (WIDTH=8, SEL_BITS=3) and a full
// size instance (WIDTH=1024, SEL_BITS=5) share clock and reset. Expected
// entries come from (i * base) % modulus computed with wide arithmetic.
module tb_xpb_table_gen;

  localparam int LW = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // small instance signals
  logic       s_start = 1'b0;
  logic [7:0] s_base = '0, s_mod = '0;
  logic       s_busy, s_done, s_ready, s_err;
  logic       s_lv = 1'b0;
  logic [2:0] s_sel = '0;
  logic [7:0] s_ld;
  logic       s_ldv;

  // large instance signals
  logic          l_start = 1'b0;
  logic [LW-1:0] l_base = '0, l_mod = '0;
  logic          l_busy, l_done, l_ready, l_err;
  logic          l_lv = 1'b0;
  logic [4:0]    l_sel = '0;
  logic [LW-1:0] l_ld;
  logic          l_ldv;

  xpb_table_gen #(.WIDTH(8), .SEL_BITS(3)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .base(s_base), .modulus(s_mod),
    .busy(s_busy), .done(s_done), .ready(s_ready), .err(s_err),
    .lookup_valid(s_lv), .lookup_sel(s_sel), .lookup_data(s_ld),
    .lookup_data_valid(s_ldv)
  );

  xpb_table_gen #(.WIDTH(LW), .SEL_BITS(5)) u_large (
    .clk(clk), .rst_n(rst_n), .start(l_start), .base(l_base), .modulus(l_mod),
    .busy(l_busy), .done(l_done), .ready(l_ready), .err(l_err),
    .lookup_valid(l_lv), .lookup_sel(l_sel), .lookup_data(l_ld),
    .lookup_data_valid(l_ldv)
  );

  // ---------------- scoreboard state ----------------
  int              n_checks = 0;
  int              n_fail   = 0;
  logic [LW-1:0]   exp_q[$];
  logic [LW-1:0]   cur_base_s, cur_mod_s, cur_base_l, cur_mod_l;
  logic [LW-1:0]   last_s;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (low 192 bits)", tag, got[191:0], exp[191:0]);
    end
  endtask

  // Reference model: plain wide multiply and modulo.
  function automatic logic [LW-1:0] ref_entry(input int i, input logic [LW-1:0] b,
                                              input logic [LW-1:0] m);
    logic [LW+7:0] p;
    logic [LW+7:0] r;
    p = (LW+8)'(i) * {8'b0, b};
    r = p % {8'b0, m};
    return r[LW-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_s(input logic [7:0] b, input logic [7:0] m);
    s_base  = b;
    s_mod   = m;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
  endtask

  task automatic start_l(input logic [LW-1:0] b, input logic [LW-1:0] m);
    l_base  = b;
    l_mod   = m;
    l_start = 1'b1;
    step();
    l_start = 1'b0;
  endtask

  // Counts cycles from the start edge until done; bounded, checked by caller.
  task automatic wait_done_s(output int cyc);
    cyc = 0;
    while (!s_done && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic wait_done_l(output int cyc);
    cyc = 0;
    while (!l_done && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  // Full build on the small instance with timing checks.
  task automatic build_s(input string tag, input logic [7:0] b, input logic [7:0] m);
    int cyc;
    cur_base_s = LW'(b);
    cur_mod_s  = LW'(m);
    start_s(b, m);
    chk({tag, "_busy_start"}, LW'(s_busy), LW'(1));
    chk({tag, "_ready_drop"}, LW'(s_ready), LW'(0));
    wait_done_s(cyc);
    chk({tag, "_done_cycles"}, LW'(cyc), LW'(7));
    chk({tag, "_ready_at_done"}, LW'(s_ready), LW'(1));
    chk({tag, "_busy_at_done"}, LW'(s_busy), LW'(0));
    step();
    chk({tag, "_done_pulse"}, LW'(s_done), LW'(0));
  endtask

  // Leaves s_lv high so consecutive calls give back-to-back lookups.
  task automatic lookup_one_s(input string tag, input int sel);
    logic [LW-1:0] e;
    s_lv  = 1'b1;
    s_sel = sel[2:0];
    exp_q.push_back(ref_entry(sel, cur_base_s, cur_mod_s));
    step();
    e = exp_q.pop_front();
    chk({tag, "_ldv"}, LW'(s_ldv), LW'(1));
    chk({tag, "_ld"}, LW'(s_ld), e);
    last_s = e;
  endtask

  task automatic lookup_blocked_s(input string tag, input int sel);
    s_lv  = 1'b1;
    s_sel = sel[2:0];
    step();
    s_lv = 1'b0;
    chk({tag, "_ldv_low"}, LW'(s_ldv), LW'(0));
    chk({tag, "_ld_hold"}, LW'(s_ld), last_s);
  endtask

  task automatic read_all_s(input string tag);
    for (int i = 0; i < 8; i++) lookup_one_s(tag, i);
    s_lv = 1'b0;
  endtask

  task automatic build_and_read_l(input string tag, input logic [LW-1:0] b,
                                  input logic [LW-1:0] m);
    int cyc;
    cur_base_l = b;
    cur_mod_l  = m;
    start_l(b, m);
    chk({tag, "_busy_start"}, LW'(l_busy), LW'(1));
    wait_done_l(cyc);
    chk({tag, "_done_cycles"}, LW'(cyc), LW'(31));
    chk({tag, "_ready"}, LW'(l_ready), LW'(1));
    for (int i = 0; i < 32; i++) begin
      l_lv  = 1'b1;
      l_sel = 5'(i);
      exp_q.push_back(ref_entry(i, cur_base_l, cur_mod_l));
      step();
      chk({tag, "_ldv"}, LW'(l_ldv), LW'(1));
      chk({tag, "_ld"}, l_ld, exp_q.pop_front());
    end
    l_lv = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int            cyc, done_cnt, done_at;
    logic [7:0]    rb, rm;
    logic [LW-1:0] wm, wb;

    last_s = '0;

    // reset state
    repeat (3) step();
    chk("rst_s_busy", LW'(s_busy), LW'(0));
    chk("rst_s_done", LW'(s_done), LW'(0));
    chk("rst_s_ready", LW'(s_ready), LW'(0));
    chk("rst_s_err", LW'(s_err), LW'(0));
    chk("rst_s_ldv", LW'(s_ldv), LW'(0));
    chk("rst_s_ld", LW'(s_ld), LW'(0));
    chk("rst_l_ready", LW'(l_ready), LW'(0));
    chk("rst_l_ld", l_ld, LW'(0));
    rst_n = 1'b1;
    step();

    // basic build M=13 base=5 and full readback (0,5,10,2,7,12,4,9)
    build_s("t1", 8'd5, 8'd13);
    read_all_s("t1_rd");

    // back-to-back 7,0,7
    lookup_one_s("t6_a", 7);
    lookup_one_s("t6_b", 0);
    lookup_one_s("t6_c", 7);
    s_lv = 1'b0;
    step();
    chk("t6_idle_ldv", LW'(s_ldv), LW'(0));
    chk("t6_idle_hold", LW'(s_ld), last_s);

    // rejected start, then a valid start clears err
    start_s(8'd13, 8'd13);
    chk("t2_err", LW'(s_err), LW'(1));
    chk("t2_ready", LW'(s_ready), LW'(0));
    chk("t2_busy", LW'(s_busy), LW'(0));
    step();
    chk("t2_busy_later", LW'(s_busy), LW'(0));
    lookup_blocked_s("t2_lk", 3);
    start_s(8'd0, 8'd0);
    chk("t2_err_m0", LW'(s_err), LW'(1));
    build_s("t2_valid", 8'd5, 8'd13);
    chk("t2_err_clear", LW'(s_err), LW'(0));

    // start pulsed mid-GEN with new pins: ignored, one done
    cur_base_s = LW'(5);
    cur_mod_s  = LW'(13);
    start_s(8'd5, 8'd13);
    cyc = 0; done_cnt = 0; done_at = -1;
    step(); cyc++;
    step(); cyc++;
    s_base = 8'd1; s_mod = 8'd7; s_start = 1'b1;
    step(); cyc++;
    s_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(); cyc++;
      if (s_done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
    end
    chk("t3_done_cnt", LW'(done_cnt), LW'(1));
    chk("t3_done_at", LW'(done_at), LW'(7));
    read_all_s("t3_rd");
    // rebuild from ready with base=1: entries 0..7
    build_s("t3_rebuild", 8'd1, 8'd13);
    read_all_s("t3_rb_rd");

    // edge: M=1 gives an all-zero table
    build_s("m1", 8'd0, 8'd1);
    read_all_s("m1_rd");

    // randomized small builds, some with rejected operands
    for (int r = 0; r < 8; r++) begin
      rm = 8'($urandom_range(1, 127) * 2 + 1);
      if ($urandom_range(0, 3) == 0) begin
        rb = 8'($urandom_range(int'(rm), 255));
        start_s(rb, rm);
        chk("rnd_bad_err", LW'(s_err), LW'(1));
        chk("rnd_bad_ready", LW'(s_ready), LW'(0));
        lookup_blocked_s("rnd_bad_lk", int'($urandom_range(0, 7)));
      end else begin
        rb = 8'($urandom_range(0, int'(rm) - 1));
        build_s("rnd", rb, rm);
        for (int k = 0; k < 6; k++) lookup_one_s("rnd_lk", int'($urandom_range(0, 7)));
        s_lv = 1'b0;
      end
    end

    // async reset mid-GEN
    build_s("t4_pre", 8'd5, 8'd13);
    lookup_one_s("t4_pre_lk", 3);
    s_lv = 1'b0;
    start_s(8'd5, 8'd13);
    step(); step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_busy", LW'(s_busy), LW'(0));
    chk("t4_ready", LW'(s_ready), LW'(0));
    chk("t4_done", LW'(s_done), LW'(0));
    chk("t4_err", LW'(s_err), LW'(0));
    chk("t4_ld", LW'(s_ld), LW'(0));
    chk("t4_ldv", LW'(s_ldv), LW'(0));
    step();
    rst_n = 1'b1;
    step();
    last_s = '0;
    lookup_blocked_s("t4_post_lk", 1);

    // full width: M = 2**1023 + 1155, base = 2**1022
    wm = '0; wm[1023] = 1'b1; wm = wm + LW'(1155);
    wb = '0; wb[1022] = 1'b1;
    build_and_read_l("t5", wb, wm);

    // full width random odd modulus
    for (int k = 0; k < 32; k++) wm[k*32 +: 32] = $urandom();
    wm[0] = 1'b1;
    for (int k = 0; k < 32; k++) wb[k*32 +: 32] = $urandom();
    wb = wb % wm;
    build_and_read_l("t5_rnd", wb, wm);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
